// File: rtl/rf_pkg.sv
// Shared types and constants for the range finder: FSM state, default sizes, all-ones helper.
`timescale 1ns/1ps
package rf_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam int RF_WIDTH_DEF    = 8;
  localparam int RF_AVG_LOG2_DEF = 2;

  // All-ones value of width w, returned in a 32-bit container for the caller to truncate.
  function automatic logic [31:0] rf_ones(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/rf_edge_detect.sv
// 1-bit rising-edge detector; rise_o is combinational from sig_i and a 1-cycle registered copy.
// No latency beyond the register; no backpressure.
`timescale 1ns/1ps
module rf_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sig_q <= 1'b0;
    else       sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/range_finder_3.sv
// Time-of-flight range finder: range/valid/timeout registered one cycle after the deciding edge, no backpressure.
// Optional windowed averaging (avg_range/avg_valid) is built when RF_AVERAGE_EN is defined.
`timescale 1ns/1ps
module range_finder_3
  import rf_pkg::*;
#(
  parameter int WIDTH     = RF_WIDTH_DEF,
  parameter int MAX_COUNT = 2**WIDTH - 1
`ifdef RF_AVERAGE_EN
  ,
  parameter int AVG_LOG2  = RF_AVG_LOG2_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             em_sensor,
  input  logic             rec_sensor,
  output logic [WIDTH-1:0] range,
  output logic             valid,
  output logic             timeout,
  output logic             busy
`ifdef RF_AVERAGE_EN
  ,
  output logic [WIDTH-1:0] avg_range,
  output logic             avg_valid
`endif
);

  localparam logic [WIDTH-1:0] ALL_ONES = WIDTH'(rf_ones(WIDTH));
  localparam logic [WIDTH-1:0] MAX_C    = WIDTH'(MAX_COUNT);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] range_q, range_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             em_rise, rec_rise;

  rf_edge_detect u_em_edge (
    .clk_i  (clk),
    .rst_i  (rst),
    .sig_i  (em_sensor),
    .rise_o (em_rise)
  );

  rf_edge_detect u_rec_edge (
    .clk_i  (clk),
    .rst_i  (rst),
    .sig_i  (rec_sensor),
    .rise_o (rec_rise)
  );

  // Priority in COUNT: echo, then timeout, then retrigger.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    range_d   = range_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (em_rise) begin
          cnt_d   = WIDTH'(1);
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (rec_rise) begin
          range_d = cnt_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == MAX_C) begin
          range_d   = ALL_ONES;
          valid_d   = 1'b1;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else if (em_rise) begin
          cnt_d = WIDTH'(1);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      range_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      range_q   <= range_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign range   = range_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;
  assign busy    = (state_q == COUNT);

`ifdef RF_AVERAGE_EN
  localparam int SUM_W = WIDTH + AVG_LOG2;
  localparam logic [AVG_LOG2-1:0] LAST_SMP = AVG_LOG2'(rf_ones(AVG_LOG2));

  logic [SUM_W-1:0]    sum_q, sum_d, sum_new;
  logic [AVG_LOG2-1:0] smp_q, smp_d;
  logic [WIDTH-1:0]    avg_q, avg_d;
  logic                avg_vld_q, avg_vld_d;

  // Samples are taken from the next-state result so avg_valid lines up with valid.
  always_comb begin
    sum_new   = sum_q + SUM_W'(range_d);
    sum_d     = sum_q;
    smp_d     = smp_q;
    avg_d     = avg_q;
    avg_vld_d = 1'b0;
    if (valid_d && !timeout_d) begin
      if (smp_q == LAST_SMP) begin
        avg_d     = WIDTH'(sum_new >> AVG_LOG2);
        avg_vld_d = 1'b1;
        sum_d     = '0;
        smp_d     = '0;
      end else begin
        sum_d = sum_new;
        smp_d = smp_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q     <= '0;
      smp_q     <= '0;
      avg_q     <= '0;
      avg_vld_q <= 1'b0;
    end else begin
      sum_q     <= sum_d;
      smp_q     <= smp_d;
      avg_q     <= avg_d;
      avg_vld_q <= avg_vld_d;
    end
  end

  assign avg_range = avg_q;
  assign avg_valid = avg_vld_q;
`endif

endmodule

// File: tb/tb_range_finder_3.sv
// Scoreboard bench for range_finder_3: stimulus pushes expected results, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_range_finder_3;

  localparam int W     = 8;
  localparam int MAXC  = 200;
  localparam int AVG_N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         em_sensor = 1'b0;
  logic         rec_sensor = 1'b0;
  logic [W-1:0] range;
  logic         valid, timeout, busy;
`ifdef RF_AVERAGE_EN
  logic [W-1:0] avg_range;
  logic         avg_valid;
  int           samples[$];
  int           avg_exp[$];
`endif

  typedef struct {
    int rng;
    bit to;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #20 clk = ~clk;

  range_finder_3 #(.WIDTH(W), .MAX_COUNT(MAXC)) dut (
    .clk        (clk),
    .rst        (rst),
    .em_sensor  (em_sensor),
    .rec_sensor (rec_sensor),
    .range      (range),
    .valid      (valid),
    .timeout    (timeout),
    .busy       (busy)
`ifdef RF_AVERAGE_EN
    ,
    .avg_range  (avg_range),
    .avg_valid  (avg_valid)
`endif
  );

  function automatic void check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Monitor: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (timeout) check("timeout_with_valid", int'(valid), 1);
      if (valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", int'(valid), 0);
        end else begin
          e = exp_q.pop_front();
          check("range", int'(range), e.rng);
          check("timeout_flag", int'(timeout), int'(e.to));
        end
      end
`ifdef RF_AVERAGE_EN
      if (avg_valid) begin
        if (avg_exp.size() == 0) check("unexpected_avg_valid", int'(avg_valid), 0);
        else check("avg_range", int'(avg_range), avg_exp.pop_front());
      end
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #5;
  endtask

  // em rises in cycle 0 (held em_len cycles), optional second em rise at cycle g,
  // rec rises at cycle r (r<0: never), optional rec rise together with em in cycle 0.
  task automatic measure(input int g, input int r, input bit rec0, input int em_len);
    int   start, last;
    bit   to;
    exp_t e;
    start = (g > 0 && r >= 0 && g < r) ? g : ((g > 0 && r < 0) ? g : 0);
    to    = !(r >= 0 && (r - start) <= MAXC);
    e.to  = to;
    e.rng = to ? 255 : (r - start);
    exp_q.push_back(e);
`ifdef RF_AVERAGE_EN
    if (!to) begin
      samples.push_back(e.rng);
      if (samples.size() == AVG_N) begin
        int s;
        s = 0;
        foreach (samples[i]) s += samples[i];
        avg_exp.push_back(s / AVG_N);
        samples.delete();
      end
    end
`endif
    last = to ? start + MAXC + 3 : r + 3;
    for (int c = 0; c <= last; c++) begin
      em_sensor  = (c < em_len) || (g > 0 && c == g);
      rec_sensor = (rec0 && c == 0) || (r >= 0 && c >= r && c < r + 2);
      if (c == 1) check("busy_counting", int'(busy), 1);
      tick();
    end
    em_sensor  = 1'b0;
    rec_sensor = 1'b0;
    tick();
    tick();
    check("busy_after", int'(busy), 0);
    check("range_hold", int'(range), e.rng);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, g, el;
    #30;
    check("reset_range", int'(range), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_timeout", int'(timeout), 0);
    check("reset_busy", int'(busy), 0);
`ifdef RF_AVERAGE_EN
    check("reset_avg_range", int'(avg_range), 0);
    check("reset_avg_valid", int'(avg_valid), 0);
`endif
    #25;
    rst = 1'b0;
    tick();

    // Averaging window: 10, timeout, 20, 31, 40 -> mean 25.
    measure(0, 10, 1'b0, 1);
    measure(0, -1, 1'b0, 2);
    measure(0, 20, 1'b0, 1);
    measure(0, 31, 1'b0, 3);
    measure(0, 40, 1'b0, 1);

    measure(0, 17, 1'b0, 2);   // basic
    measure(0, -1, 1'b0, 2);   // timeout
    measure(5, 14, 1'b0, 2);   // retrigger -> 9
    measure(30, 30, 1'b1, 1);  // simultaneous in IDLE then in COUNT -> 30
    measure(0, 1, 1'b0, 1);
    measure(0, MAXC, 1'b0, 1);
    measure(0, MAXC + 1, 1'b0, 1);

    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        g  = $urandom_range(2, 100);
        r  = g + $urandom_range(0, 150);
        el = 1;
      end else begin
        g  = 0;
        r  = $urandom_range(1, 230);
        el = $urandom_range(1, 4);
      end
      measure(g, r, 1'b0, el);
    end

    // Asynchronous reset at cnt == 40.
    for (int c = 0; c < 40; c++) begin
      em_sensor = (c < 2);
      tick();
    end
    rst = 1'b1;
    #1;
    check("midreset_busy", int'(busy), 0);
    check("midreset_range", int'(range), 0);
    check("midreset_valid", int'(valid), 0);
`ifdef RF_AVERAGE_EN
    samples.delete();
`endif
    em_sensor = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    measure(0, 12, 1'b0, 1);

    repeat (4) tick();
    check("scoreboard_drained", exp_q.size(), 0);
`ifdef RF_AVERAGE_EN
    check("avg_scoreboard_drained", avg_exp.size(), 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/range_finder_3.md
Name: range_finder_3

Overview:
- Parametrised time-of-flight range finder, successor to the fixed 8-bit range finder.
- Measures clock cycles from the rising edge of the emitter pulse (em_sensor) to the rising edge of the receiver echo (rec_sensor).
- Adds configurable counter width, programmable timeout, a valid/timeout handshake and retrigger handling, with optional windowed averaging.
- Sits between the sensor front end (inputs already synchronised to clk) and the host range register.

Parameters:
- WIDTH, 8: width of the range counter and range output.
- MAX_COUNT, 2**WIDTH-1: timeout threshold in cycles. Must satisfy 1 <= MAX_COUNT <= 2**WIDTH-1.
- AVG_LOG2, 2: averaging window is 2**AVG_LOG2 samples. Used only with RF_AVERAGE_EN.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- em_sensor  in  1  emitter pulse, synchronous to clk.
- rec_sensor  in  1  receiver echo, synchronous to clk.
- range  out  WIDTH  last measured distance in cycles; holds between measurements.
- valid  out  1  one-cycle pulse when range updates.
- timeout  out  1  one-cycle pulse coincident with valid when no echo arrived.
- busy  out  1  high while in COUNT.
- avg_range  out  WIDTH  windowed mean. Present only with RF_AVERAGE_EN.
- avg_valid  out  1  one-cycle pulse when avg_range updates. Present only with RF_AVERAGE_EN.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. Asserting rst, including mid-measurement, immediately forces:
  - state to IDLE;
  - counter, range, valid, timeout, busy and the edge registers to 0;
  - averaging state to 0.
- Edge detection: em_rise = em_sensor & ~em_q, and likewise rec_rise; em_q and rec_q are 1-cycle registered copies. A level held high produces exactly one rise.
- IDLE:
  - em_rise -> cnt <= 1, state <= COUNT.
  - rec_rise is ignored.
  - If em_rise and rec_rise occur in the same cycle, em wins and rec is dropped.
- COUNT (busy = 1):
  - rec_rise -> range <= cnt, valid pulses 1 cycle, state <= IDLE.
  - Otherwise, if cnt == MAX_COUNT -> range <= all ones, valid = timeout = 1 for 1 cycle, state <= IDLE.
  - Otherwise, if em_rise -> retrigger: cnt <= 1, stay in COUNT; no valid pulse.
  - Otherwise cnt <= cnt + 1.
- Priority in COUNT: rec_rise > timeout > em_rise. An em_rise in the cycle rec completes is dropped.
- Range definition: range = t_rec - t_em, where both times are the cycles in which the respective rise is detected. Example: em detected at cycle 10 and rec at cycle 27 gives range = 17.
- Latency: valid and range are registered; they appear the cycle after rec_rise is detected.
- Width rule: cnt is WIDTH bits and never wraps, because it exits at MAX_COUNT. A genuine echo at cnt == MAX_COUNT still reports MAX_COUNT, since rec has priority over timeout.

Optional Feature:
- Macro: RF_AVERAGE_EN.
- Defined:
  - Accumulator of WIDTH+AVG_LOG2 bits sums each non-timeout range. A sample counter of AVG_LOG2 bits tracks the window.
  - When the 2**AVG_LOG2-th sample is added: avg_range <= (sum + new) >> AVG_LOG2 (truncating), avg_valid pulses, accumulator and sample counter clear.
  - Timeout results are excluded from the average and do not advance the sample counter.
- Undefined: avg_range, avg_valid and all averaging logic are absent.

Decomposition:
- Shared package rf_pkg:
  - state typedef, IDLE/COUNT;
  - function returning the all-ones value for a given width;
  - default constants for WIDTH and AVG_LOG2.
- Sub-module rf_edge_detect: 1-bit registered rising-edge detector, with asynchronous active-high reset; instantiated twice.

Test Plan:
- Bench setup: 40 ns clock, WIDTH=8, MAX_COUNT=200. rst high 55 ns, then low.
- Basic measurement: em pulse of 2 cycles; rec rises 17 cycles after em is detected -> range=17, valid 1 cycle, timeout=0, busy low afterwards.
- Timeout: em pulse with no rec -> after 200 cycles range=255, valid=timeout=1 for 1 cycle, state IDLE.
- Retrigger: em rise; second em rise 5 cycles later; rec 9 cycles after the second -> range=9, exactly one valid.
- Simultaneous edges: em and rec rise together in IDLE -> measurement starts, no valid. rec and em rise together in COUNT at cnt=30 -> range=30, state IDLE, em dropped.
- Reset mid-operation: rst asserted at cnt=40 -> busy, range and valid are 0 asynchronously. The next measurement (em, then rec 12 cycles later) yields range=12.
- RF_AVERAGE_EN with AVG_LOG2=2: ranges 10, 20, 31, 40 with one timeout between them -> a single avg_valid, avg_range=25.
